// File: rtl/pwm_deadtime.sv
// Three-phase dead-time inserter with gate-drive interlock.
// Each phase passes through an all-off dead interval before either gate is turned on.
module pwm_deadtime #(
    parameter int DT_WIDTH = 8,
    parameter int MIN_DT   = 2
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic [2:0]          pwm_in,
    input  logic                dt_wen,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                enable,
    input  logic                fault_n,
    input  logic                fault_clear,
    output logic [2:0]          gate_hi,
    output logic [2:0]          gate_lo,
    output logic                fault_latched,
    output logic                busy
);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DEAD  = 2'd1,
        HI_ON = 2'd2,
        LO_ON = 2'd3
    } phase_state_e;

    localparam logic [DT_WIDTH-1:0] MIN_DT_V = DT_WIDTH'(MIN_DT);
    localparam logic [DT_WIDTH-1:0] ONE_V    = DT_WIDTH'(1);

    function automatic logic [DT_WIDTH-1:0] clamp_dt(input logic [DT_WIDTH-1:0] v);
        return (v < MIN_DT_V) ? MIN_DT_V : v;
    endfunction

    logic                sync1_q, sync2_q;
    logic                fault_q, fault_d;
    logic [DT_WIDTH-1:0] dt_q, dt_d;
    logic [DT_WIDTH-1:0] dt_load;
    logic                kill;

    phase_state_e        state_q [3];
    phase_state_e        state_d [3];
    logic [DT_WIDTH-1:0] cnt_q   [3];
    logic [DT_WIDTH-1:0] cnt_d   [3];
    logic [2:0]          tgt_q, tgt_d;

    logic [2:0]          gate_hi_q, gate_hi_d;
    logic [2:0]          gate_lo_q, gate_lo_d;
    logic                busy_q, busy_d;

    // Kill acts on the same edge it is sampled; the registered gates make it visible one stage later.
    assign kill    = !enable || fault_q;
    assign dt_load = dt_q - ONE_V;

    always_comb begin
        dt_d = dt_wen ? clamp_dt(dead_time) : dt_q;

        // A synchronized fault sets the flag and beats a concurrent clear.
        if (!sync2_q) begin
            fault_d = 1'b1;
        end else if (fault_clear) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end

        tgt_d     = tgt_q;
        gate_hi_d = '0;
        gate_lo_d = '0;
        busy_d    = 1'b0;

        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            if (kill) begin
                state_d[i] = OFF;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    OFF: begin
                        state_d[i] = DEAD;
                        cnt_d[i]   = dt_load;
                        tgt_d[i]   = pwm_in[i];
                    end
                    DEAD: begin
                        // A request change restarts the interval rather than shortening it.
                        if (pwm_in[i] != tgt_q[i]) begin
                            cnt_d[i] = dt_load;
                            tgt_d[i] = pwm_in[i];
                        end else if (cnt_q[i] == '0) begin
                            state_d[i] = tgt_q[i] ? HI_ON : LO_ON;
                        end else begin
                            cnt_d[i] = cnt_q[i] - ONE_V;
                        end
                    end
                    HI_ON: begin
                        if (!pwm_in[i]) begin
                            state_d[i] = DEAD;
                            cnt_d[i]   = dt_load;
                            tgt_d[i]   = 1'b0;
                        end
                    end
                    LO_ON: begin
                        if (pwm_in[i]) begin
                            state_d[i] = DEAD;
                            cnt_d[i]   = dt_load;
                            tgt_d[i]   = 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = OFF;
                        cnt_d[i]   = '0;
                    end
                endcase
            end

            gate_hi_d[i] = (state_d[i] == HI_ON);
            gate_lo_d[i] = (state_d[i] == LO_ON);
            busy_d       = busy_d || (state_d[i] == DEAD);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            fault_q   <= 1'b0;
            dt_q      <= MIN_DT_V;
            tgt_q     <= '0;
            gate_hi_q <= '0;
            gate_lo_q <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= OFF;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= fault_n;
            sync2_q   <= sync1_q;
            fault_q   <= fault_d;
            dt_q      <= dt_d;
            tgt_q     <= tgt_d;
            gate_hi_q <= gate_hi_d;
            gate_lo_q <= gate_lo_d;
            busy_q    <= busy_d;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign gate_hi       = gate_hi_q;
    assign gate_lo       = gate_lo_q;
    assign fault_latched = fault_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: a run-length reference model pushes expected
// outputs per edge, a separate monitor pops and compares after each rising edge.
module tb_pwm_deadtime;

    localparam int DT_WIDTH = 8;
    localparam int MIN_DT   = 2;

    logic                clk = 1'b0;
    logic                rstb = 1'b0;
    logic [2:0]          pwm_in = '0;
    logic                dt_wen = 1'b0;
    logic [DT_WIDTH-1:0] dead_time = '0;
    logic                enable = 1'b0;
    logic                fault_n = 1'b1;
    logic                fault_clear = 1'b0;
    logic [2:0]          gate_hi;
    logic [2:0]          gate_lo;
    logic                fault_latched;
    logic                busy;

    pwm_deadtime #(.DT_WIDTH(DT_WIDTH), .MIN_DT(MIN_DT)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .pwm_in       (pwm_in),
        .dt_wen       (dt_wen),
        .dead_time    (dead_time),
        .enable       (enable),
        .fault_n      (fault_n),
        .fault_clear  (fault_clear),
        .gate_hi      (gate_hi),
        .gate_lo      (gate_lo),
        .fault_latched(fault_latched),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] hi;
        logic [2:0] lo;
        logic       flag;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: a phase's gate is on once its current request run has lasted
    // at least the dead time captured when the run began.
    bit   m_active [3];
    bit   m_val    [3];
    int   m_len    [3];
    int   m_rdt    [3];
    bit   m_flag, m_s1, m_s2;
    int   m_dt;

    logic [2:0] c_pwm = '0;
    logic       c_en = 1'b0, c_fn = 1'b1, c_fc = 1'b0, c_wen = 1'b0;
    logic [7:0] c_dt = '0;

    task automatic model_reset();
        m_flag = 1'b0;
        m_s1   = 1'b1;
        m_s2   = 1'b1;
        m_dt   = MIN_DT;
        for (int i = 0; i < 3; i++) begin
            m_active[i] = 1'b0;
            m_val[i]    = 1'b0;
            m_len[i]    = 0;
            m_rdt[i]    = MIN_DT;
        end
    endtask

    task automatic step();
        exp_t e;
        bit   kill;
        @(negedge clk);
        rstb        = 1'b1;
        pwm_in      = c_pwm;
        enable      = c_en;
        fault_n     = c_fn;
        fault_clear = c_fc;
        dt_wen      = c_wen;
        dead_time   = c_dt;

        e    = '0;
        kill = !c_en || m_flag;
        for (int i = 0; i < 3; i++) begin
            if (kill) begin
                m_active[i] = 1'b0;
            end else if (!m_active[i] || (c_pwm[i] != m_val[i])) begin
                m_active[i] = 1'b1;
                m_val[i]    = c_pwm[i];
                m_len[i]    = 0;
                m_rdt[i]    = m_dt;
            end else if (m_len[i] < 100000) begin
                m_len[i]++;
            end
            if (m_active[i]) begin
                if (m_len[i] >= m_rdt[i]) begin
                    if (m_val[i]) e.hi[i] = 1'b1;
                    else          e.lo[i] = 1'b1;
                end else begin
                    e.busy = 1'b1;
                end
            end
        end
        if (!m_s2)     m_flag = 1'b1;
        else if (c_fc) m_flag = 1'b0;
        e.flag = m_flag;
        m_s2 = m_s1;
        m_s1 = c_fn;
        if (c_wen) m_dt = (int'(c_dt) < MIN_DT) ? MIN_DT : int'(c_dt);
        exp_q.push_back(e);
        c_wen = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_idle(input string name);
        n_vec++;
        if ({gate_hi, gate_lo, fault_latched, busy} !== 8'h00) begin
            n_err++;
            $display("FAIL %s: got hi=%b lo=%b flag=%b busy=%b, required all zero",
                     name, gate_hi, gate_lo, fault_latched, busy);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rstb = 1'b0;
        #1 check_idle("async_reset");
        exp_q.delete();
        model_reset();
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({gate_hi, gate_lo, fault_latched, busy} !== e) begin
                    n_err++;
                    $display("FAIL scoreboard t=%0t: got hi=%b lo=%b flag=%b busy=%b, required hi=%b lo=%b flag=%b busy=%b",
                             $time, gate_hi, gate_lo, fault_latched, busy, e.hi, e.lo, e.flag, e.busy);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin : stimulus
        model_reset();
        #23 check_idle("reset_state");

        // Startup from reset with the default dead time.
        c_en = 1'b1; c_pwm = 3'b000;
        tick(6);

        // Dead time 4, phase A low-to-high.
        c_wen = 1'b1; c_dt = 8'd4; tick(4);
        c_pwm = 3'b001; tick(8);

        // Dead time 6, short high pulse on A must not reach the high gate.
        c_wen = 1'b1; c_dt = 8'd6; c_pwm = 3'b000; tick(12);
        c_pwm = 3'b001; tick(3);
        c_pwm = 3'b000; tick(10);

        // Programmed values below the minimum are clamped.
        c_wen = 1'b1; c_dt = 8'd0; tick(1);
        c_pwm = 3'b101; tick(5);
        c_wen = 1'b1; c_dt = 8'd1; tick(1);
        c_pwm = 3'b010; tick(5);

        // One-cycle fault pulse while A is high, then clear and restart.
        c_pwm = 3'b001; tick(6);
        c_fn = 1'b0; tick(1);
        c_fn = 1'b1; tick(5);
        c_fc = 1'b1; tick(1);
        c_fc = 1'b0; tick(6);

        // Enable dropped during B's dead interval, then fault and clear together.
        c_wen = 1'b1; c_dt = 8'd5; tick(1);
        c_pwm = 3'b001; tick(8);
        c_pwm = 3'b011; tick(2);
        c_en = 1'b0; tick(2);
        c_en = 1'b1; tick(8);
        c_fn = 1'b0; tick(3);
        c_fc = 1'b1; tick(2);
        c_fn = 1'b1; tick(4);
        c_fc = 1'b0; tick(8);

        async_reset();
        c_wen = 1'b1; c_dt = 8'd3; tick(8);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 5) == 0) c_pwm[i] = ~c_pwm[i];
            if ($urandom_range(0, 39) == 0) begin
                c_wen = 1'b1;
                c_dt  = 8'($urandom_range(0, 9));
            end
            c_en = ($urandom_range(0, 99) != 0);
            c_fn = ($urandom_range(0, 299) != 0);
            c_fc = ($urandom_range(0, 19) == 0);
            if (n == 1500) async_reset();
            step();
        end

        c_en = 1'b1; c_fn = 1'b1; c_fc = 1'b1; tick(4);
        @(negedge clk);
        @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
